// File: rtl/serializer_scheduler_pkg.sv
// Shared types and helpers for the serializer scheduler.
package serializer_scheduler_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBody = 1'b1
    } sched_state_e;

    localparam logic [31:0] IdleWordDefault = 32'h3C3C_3C3C;
    localparam logic [23:0] HdrTagDefault   = 24'hA5F00F;

    // Header word announcing which requester owns the following packet.
    function automatic logic [31:0] build_header(input logic [23:0] tag, input logic [3:0] id);
        return {tag, 4'h0, id};
    endfunction

    // Round-robin successor of a requester index.
    function automatic logic [3:0] next_id(input logic [3:0] id, input int unsigned n);
        return (int'(id) >= int'(n) - 1) ? 4'd0 : id + 4'd1;
    endfunction

endpackage

// File: rtl/serializer_scheduler_rr_pick.sv
// Combinational cyclic priority picker: first set request at or after the pointer.
module serializer_scheduler_rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [3:0]   i_ptr,
    output logic [N-1:0] o_grant,
    output logic [3:0]   o_idx,
    output logic         o_any
);

    localparam int NI = int'(N);

    logic w_found;

    // Scan distances 0..N-1 from the pointer; the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < NI; j++) begin
                if (!w_found && i_req[j] && (j == ((int'(i_ptr) + k) % NI))) begin
                    w_found    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = 4'(j);
                end
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/serializer_scheduler.sv
// Shares one word serializer among NREQ packet sources with one word per slot.
module serializer_scheduler
    import serializer_scheduler_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WORD_PERIOD = 8,
    parameter logic [31:0] IDLE_WORD   = IdleWordDefault,
    parameter logic [23:0] HDR_TAG     = HdrTagDefault,
    parameter int unsigned MAX_STALL   = 15
) (
    input  logic                 FSclk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          ser_data,
    output logic                 ser_valid,
    output logic [3:0]           grant_id,
    output logic                 busy,
    output logic                 abort_err
);

    localparam int unsigned SW = (WORD_PERIOD > 1) ? $clog2(WORD_PERIOD) : 1;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SW-1:0] SlotLast = SW'(WORD_PERIOD - 1);

    sched_state_e    r_state, w_state_d;
    logic [SW-1:0]   r_slot;
    logic [3:0]      r_rr_ptr, w_rr_ptr_d;
    logic [7:0]      r_stall_cnt, w_stall_cnt_d, w_stall_inc;
    logic [3:0]      r_grant_id, w_grant_id_d;
    logic [NREQ-1:0] r_grant_oh, w_grant_oh_d;
    logic            r_busy, w_busy_d;
    logic [31:0]     r_ser_data, w_ser_data_d;
    logic            r_ser_valid, w_ser_valid_d;
    logic            r_abort, w_abort_d;

    logic            w_slot;
    logic [IW-1:0]   w_gid;
    logic [31:0]     w_words [NREQ];
    logic [NREQ-1:0] w_pick_grant;
    logic [3:0]      w_pick_idx;
    logic            w_pick_any;

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_words
        assign w_words[g] = req_data[32*g +: 32];
    end

    assign w_slot      = enable && (r_slot == SlotLast);
    assign w_gid       = r_grant_id[IW-1:0];
    assign w_stall_inc = r_stall_cnt + 8'd1;

    serializer_scheduler_rr_pick #(
        .N (NREQ)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Slot counter: wraps while enabled, parked at zero otherwise.
    always_ff @(posedge FSclk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot <= '0;
        end else if (!enable || (r_slot == SlotLast)) begin
            r_slot <= '0;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // Slot decision: header, packet word or filler, plus arbitration bookkeeping.
    always_comb begin
        w_state_d     = r_state;
        w_rr_ptr_d    = r_rr_ptr;
        w_stall_cnt_d = r_stall_cnt;
        w_grant_id_d  = r_grant_id;
        w_grant_oh_d  = r_grant_oh;
        w_busy_d      = r_busy;
        w_ser_data_d  = r_ser_data;
        w_ser_valid_d = 1'b0;
        w_abort_d     = 1'b0;
        req_ready     = '0;
        if (w_slot) begin
            w_ser_valid_d = 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_any) begin
                        w_grant_id_d  = w_pick_idx;
                        w_grant_oh_d  = w_pick_grant;
                        w_ser_data_d  = build_header(HDR_TAG, w_pick_idx);
                        w_stall_cnt_d = 8'd0;
                        w_busy_d      = 1'b1;
                        w_state_d     = StBody;
                    end else begin
                        w_ser_data_d = IDLE_WORD;
                    end
                end
                StBody: begin
                    if (req_valid[w_gid]) begin
                        req_ready     = r_grant_oh;
                        w_ser_data_d  = w_words[w_gid];
                        w_stall_cnt_d = 8'd0;
                        if (req_last[w_gid]) begin
                            w_rr_ptr_d = next_id(r_grant_id, NREQ);
                            w_busy_d   = 1'b0;
                            w_state_d  = StIdle;
                        end
                    end else begin
                        w_ser_data_d = IDLE_WORD;
                        if (w_stall_inc >= 8'(MAX_STALL)) begin
                            w_abort_d     = 1'b1;
                            w_stall_cnt_d = 8'd0;
                            w_rr_ptr_d    = next_id(r_grant_id, NREQ);
                            w_busy_d      = 1'b0;
                            w_state_d     = StIdle;
                        end else begin
                            w_stall_cnt_d = w_stall_inc;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Architectural state and registered serializer-facing outputs.
    always_ff @(posedge FSclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_rr_ptr    <= 4'd0;
            r_stall_cnt <= 8'd0;
            r_grant_id  <= 4'd0;
            r_grant_oh  <= '0;
            r_busy      <= 1'b0;
            r_ser_data  <= 32'd0;
            r_ser_valid <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_rr_ptr    <= w_rr_ptr_d;
            r_stall_cnt <= w_stall_cnt_d;
            r_grant_id  <= w_grant_id_d;
            r_grant_oh  <= w_grant_oh_d;
            r_busy      <= w_busy_d;
            r_ser_data  <= w_ser_data_d;
            r_ser_valid <= w_ser_valid_d;
            r_abort     <= w_abort_d;
        end
    end

    assign ser_data  = r_ser_data;
    assign ser_valid = r_ser_valid;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign abort_err = r_abort;

endmodule

// File: tb/tb_serializer_scheduler.sv
// Directed bench for serializer_scheduler with hand-computed word sequences.
module tb_serializer_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned WP   = 8;
    localparam logic [31:0] IDLE = 32'h3C3C_3C3C;

    logic               FSclk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        ser_data;
    logic               ser_valid;
    logic [3:0]         grant_id;
    logic               busy;
    logic               abort_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int gap_cnt = 0;
    int dbl_cnt = 0;
    bit in_gap = 1'b0;
    logic prev_valid = 1'b0;

    logic [31:0] p_data;
    logic        p_busy;
    logic        p_abort;
    logic [3:0]  p_grant;
    int          p_cyc;
    int          last_cyc;

    serializer_scheduler #(
        .NREQ        (NREQ),
        .WORD_PERIOD (WP),
        .IDLE_WORD   (IDLE),
        .HDR_TAG     (24'hA5F00F),
        .MAX_STALL   (15)
    ) dut (
        .FSclk     (FSclk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort_err (abort_err)
    );

    always #5 FSclk = ~FSclk;

    always @(posedge FSclk) cyc++;

    always @(negedge FSclk) begin
        if (req_ready != '0) ready_cnt++;
        if (in_gap && (ser_valid || (req_ready != '0))) gap_cnt++;
        if (ser_valid && prev_valid) dbl_cnt++;
        prev_valid = ser_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        req_data[32*i +: 32] = w;
    endtask

    // Wait (bounded) for the next ser_valid pulse and capture the outputs.
    task automatic next_pulse();
        int n;
        n = 0;
        @(negedge FSclk);
        while (!ser_valid && n < 3 * WP) begin
            @(negedge FSclk);
            n++;
        end
        check("pulse_seen", {31'b0, ser_valid}, 32'd1);
        p_data   = ser_data;
        p_busy   = busy;
        p_abort  = abort_err;
        p_grant  = grant_id;
        last_cyc = p_cyc;
        p_cyc    = cyc;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        next_pulse();
        check(tag, p_data, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        p_cyc     = 0;
        last_cyc  = 0;
        #23;
        check("rst_ser_valid", {31'b0, ser_valid}, 32'd0);
        check("rst_ser_data", ser_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_grant", {28'b0, grant_id}, 32'd0);
        check("rst_ready", {28'b0, req_ready}, 32'd0);
        @(negedge FSclk);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Idle fill: pulses every WP cycles, no grants.
        expect_word("idle0", IDLE);
        check("idle0_busy", {31'b0, p_busy}, 32'd0);
        expect_word("idle1", IDLE);
        expect_word("idle2", IDLE);
        check("idle_period", p_cyc - last_cyc, WP);
        check("idle_no_ready", ready_cnt, 32'd0);

        // Requester 2, three-word packet.
        req_valid[2] = 1'b1;
        set_word(2, 32'h1111_1111);
        expect_word("p2_hdr", 32'hA5F0_0F02);
        check("p2_hdr_grant", {28'b0, p_grant}, 32'd2);
        check("p2_hdr_busy", {31'b0, p_busy}, 32'd1);
        expect_word("p2_w0", 32'h1111_1111);
        set_word(2, 32'h2222_2222);
        expect_word("p2_w1", 32'h2222_2222);
        check("p2_w1_busy", {31'b0, p_busy}, 32'd1);
        set_word(2, 32'h3333_3333);
        req_last[2] = 1'b1;
        expect_word("p2_w2", 32'h3333_3333);
        req_valid[2] = 1'b0;
        req_last[2]  = 1'b0;
        expect_word("p2_after", IDLE);
        check("p2_after_busy", {31'b0, p_busy}, 32'd0);

        // Requesters 0 and 1 both streaming 1-word packets: alternation from rr_ptr=3.
        req_valid[1:0] = 2'b11;
        req_last[1:0]  = 2'b11;
        set_word(0, 32'hAAAA_0000);
        set_word(1, 32'hBBBB_1111);
        for (int r = 0; r < 2; r++) begin
            expect_word("alt_hdr0", 32'hA5F0_0F00);
            check("alt_grant0", {28'b0, p_grant}, 32'd0);
            expect_word("alt_w0", 32'hAAAA_0000);
            expect_word("alt_hdr1", 32'hA5F0_0F01);
            check("alt_grant1", {28'b0, p_grant}, 32'd1);
            expect_word("alt_w1", 32'hBBBB_1111);
        end
        req_valid = '0;
        req_last  = '0;
        expect_word("alt_after", IDLE);

        // Requester 1 stalls after one word; abort after 15 idle slots.
        req_valid[1] = 1'b1;
        set_word(1, 32'h0101_0101);
        expect_word("st_hdr", 32'hA5F0_0F01);
        expect_word("st_w0", 32'h0101_0101);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        req_last[3]  = 1'b1;
        set_word(3, 32'h3333_0003);
        for (int i = 1; i <= 15; i++) begin
            expect_word("st_idle", IDLE);
            check("st_abort", {31'b0, p_abort}, (i == 15) ? 32'd1 : 32'd0);
        end
        @(negedge FSclk);
        check("st_abort_pulse", {31'b0, abort_err}, 32'd0);
        expect_word("st_next_hdr", 32'hA5F0_0F03);
        check("st_next_grant", {28'b0, p_grant}, 32'd3);
        expect_word("st_next_w", 32'h3333_0003);
        req_valid = '0;
        req_last  = '0;

        // Enable gap mid-packet.
        req_valid[0] = 1'b1;
        set_word(0, 32'h5000_0001);
        expect_word("en_hdr", 32'hA5F0_0F00);
        expect_word("en_w0", 32'h5000_0001);
        set_word(0, 32'h5000_0002);
        @(negedge FSclk);
        @(negedge FSclk);
        enable = 1'b0;
        in_gap = 1'b1;
        repeat (20) @(negedge FSclk);
        in_gap = 1'b0;
        enable = 1'b1;
        check("en_gap_quiet", gap_cnt, 32'd0);
        expect_word("en_w1", 32'h5000_0002);
        set_word(0, 32'h5000_0003);
        req_last[0] = 1'b1;
        expect_word("en_w2", 32'h5000_0003);
        req_valid = '0;
        req_last  = '0;

        // Async reset mid-packet, then a fresh header for the pending source.
        req_valid[2] = 1'b1;
        set_word(2, 32'h6000_0001);
        expect_word("rs_hdr", 32'hA5F0_0F02);
        expect_word("rs_w0", 32'h6000_0001);
        set_word(2, 32'h6000_0002);
        req_last[2] = 1'b1;
        repeat (3) @(negedge FSclk);
        #2 reset_n = 1'b0;
        #1;
        check("rs_async_data", ser_data, 32'd0);
        check("rs_async_busy", {31'b0, busy}, 32'd0);
        check("rs_async_grant", {28'b0, grant_id}, 32'd0);
        @(negedge FSclk);
        reset_n = 1'b1;
        expect_word("rs_new_hdr", 32'hA5F0_0F02);
        check("rs_new_grant", {28'b0, p_grant}, 32'd2);
        expect_word("rs_w1", 32'h6000_0002);
        req_valid = '0;
        req_last  = '0;
        expect_word("rs_after", IDLE);
        check("rs_after_busy", {31'b0, p_busy}, 32'd0);
        check("no_double_valid", dbl_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serializer_scheduler.md
Name: serializer_scheduler

Overview:
- Shares one BigSerialize-style 32-bit word serializer between NREQ packet sources, e.g. register readback and hit-cluster readout.
- Runs on the serializer's word clock FSclk.
- Issues exactly one dataV pulse per WORD_PERIOD cycles, carrying either a packet word or an idle filler.
- Arbitrates round-robin at packet granularity, prefixes each packet with a header word, and aborts packets whose source stalls too long.

Parameters:
NREQ, 4, number of requesters (2..16)
WORD_PERIOD, 8, FSclk cycles per serialized 32-bit word (>=2)
IDLE_WORD, 32'h3C3C_3C3C, filler word sent when nothing is granted or the source stalls
HDR_TAG, 24'hA5F00F, upper 24 bits of the packet header word
MAX_STALL, 15, consecutive stalled word slots tolerated inside a packet before abort (1..255)

Ports:
FSclk  in  1  word clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  readout enable; low freezes scheduling
req_valid  in  NREQ  requester i has a word on req_data slice i
req_last  in  NREQ  word on slice i is the final word of its packet
req_data  in  32*NREQ  packed words; slice i = bits [32i+31:32i]
req_ready  out  NREQ  one-hot word accept; a word transfers when valid&ready are both high
ser_data  out  32  word to serializer dataIn
ser_valid  out  1  one-cycle load strobe to serializer dataV
grant_id  out  4  currently granted requester (valid while busy)
busy  out  1  high from header slot through the last or aborted word
abort_err  out  1  one-cycle pulse when a packet is aborted on stall

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0; slot=0; state IDLE; rr_ptr=0; stall_cnt=0.
- Slot counter:
  - Counts 0..WORD_PERIOD-1 and wraps while enable=1.
  - A "slot" is the cycle with slot==WORD_PERIOD-1.
  - Decisions are made only in slot cycles.
  - ser_data/ser_valid are registered from the slot decision, so ser_valid is high in the cycle after the slot (latency 1).
  - ser_valid is never high in two consecutive cycles; ser_data holds its value between pulses.
- enable=0:
  - slot held at 0; req_ready=0; ser_valid=0.
  - State, grant and stall_cnt are frozen; the packet resumes when enable returns.
- req_ready:
  - Combinational, high only in a slot cycle, only for grant_id, and only in state BODY.
- State IDLE, at each slot:
  - If any req_valid is set, grant the first requester at or after rr_ptr (cyclic search).
  - Send header {HDR_TAG, 4'h0, id}; go to BODY; busy=1.
  - Otherwise send IDLE_WORD.
  - Requester data is not consumed in the header slot.
- State BODY, at each slot:
  - valid=1: accept the word, send req_data[id], stall_cnt=0.
    - If req_last: rr_ptr=id+1 mod NREQ, go to IDLE, busy drops with the ser_valid of that word.
  - valid=0: send IDLE_WORD, stall_cnt++.
    - When stall_cnt reaches MAX_STALL: pulse abort_err with that slot's ser_valid, rr_ptr=id+1, go to IDLE.
- The header is a single word; a packet of N words occupies N+1 slots when unstalled.
- Valid/last changes between slots are ignored. A source may deassert valid without penalty other than stall counting.
- Requests arriving in the same slot as a packet end are considered only at the next slot. No back-to-back header in the same slot.
- NREQ=1: rr_ptr stays 0.

Decomposition:
- Shared package:
  - State encoding (IDLE, BODY)
  - IDLE_WORD and HDR_TAG defaults
  - header-build function
- Sub-module rr_pick: a combinational cyclic priority picker (req vector, pointer -> one-hot grant, index, any). Reused by other arbiters.

Test Plan:
- Reset, no requests, WORD_PERIOD=8 → ser_valid every 8th cycle carrying 32'h3C3C3C3C; req_ready never high; busy=0.
- Requester 2 sends a 3-word packet (0x11111111, 0x22222222, 0x33333333 last) → ser_data sequence A5F00F02, 11111111, 22222222, 33333333 on consecutive pulses; then idle words; rr_ptr=3.
- Requesters 0 and 1 both valid continuously with 1-word packets → grants alternate 0, 1, 0, 1, with a header before each word.
- Requester 1 stalls mid-packet for 15 slots with MAX_STALL=15 → 15 idle words; abort_err pulses once on the 15th; next grant goes to another valid requester.
- enable dropped for 20 cycles mid-packet → no ser_valid and no req_ready during the gap; the packet resumes with the next word with no duplicate header.
- reset_n asserted mid-packet → outputs 0 immediately (async); after release, a new header is sent for the pending requester.
